// File: rtl/snurisc_run_pkg.sv
// snurisc run/step controller shared definitions: command opcodes and FSM encoding.
// No logic; imported by the controller and its testbench.
// Opcode values follow the front-end command interface encoding.
package snurisc_run_pkg;

    // Command opcodes carried on i_cmd_op
    localparam logic [1:0] OP_HALT       = 2'd0;
    localparam logic [1:0] OP_RUN_FREE   = 2'd1;
    localparam logic [1:0] OP_RUN_COUNT  = 2'd2;
    localparam logic [1:0] OP_CORE_RESET = 2'd3;

    // Controller state encoding
    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_CRST     = 2'd1;
    localparam logic [1:0] ST_RUN_FREE = 2'd2;
    localparam logic [1:0] ST_RUN_CNT  = 2'd3;

    // True for both run states (cores clocked, cycle counter advancing)
    function automatic logic is_run_state(input logic [1:0] st);
        return (st == ST_RUN_FREE) || (st == ST_RUN_CNT);
    endfunction

endpackage

// File: rtl/snurisc_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
// Latency: value updates at the edge after clr/inc. Ports: clk, rst (sync, high), clr, inc, cnt.
// No backpressure; holds at all-ones instead of wrapping.
module snurisc_sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/snurisc_run_ctrl.sv
// Command-driven run/step controller producing per-core clock enables and a shared core reset.
// Latency: a command accepted at edge T affects o_clock_en/o_core_reset/o_done from cycle T+1.
// Backpressure: o_cmd_ready is 1 in IDLE, HALT-only while running, 0 during core reset.
// Ports: i_clk, i_reset (sync, high), i_cmd_* command channel, o_clock_en[NUM_CH],
// o_core_reset, o_busy, o_done (one-cycle pulse), o_cycles (saturating run-cycle count).
// Optional SNURISC_RUNCTRL_BREAK_EN adds i_pc, i_bp_addr, i_bp_valid, o_bp_hit (PC breakpoint).
module snurisc_run_ctrl
    import snurisc_run_pkg::*;
#(
    parameter int NUM_CH     = 1,
    parameter int CNT_W      = 32,
    parameter int RST_CYCLES = 4,
    parameter int PC_W       = 32
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_cmd_valid,
    output logic                   o_cmd_ready,
    input  logic [1:0]             i_cmd_op,
    input  logic [CNT_W-1:0]       i_cmd_count,
    input  logic [NUM_CH-1:0]      i_cmd_mask,
`ifdef SNURISC_RUNCTRL_BREAK_EN
    input  logic [NUM_CH*PC_W-1:0] i_pc,
    input  logic [PC_W-1:0]        i_bp_addr,
    input  logic                   i_bp_valid,
    output logic [NUM_CH-1:0]      o_bp_hit,
`endif
    output logic [NUM_CH-1:0]      o_clock_en,
    output logic                   o_core_reset,
    output logic                   o_busy,
    output logic                   o_done,
    output logic [CNT_W-1:0]       o_cycles
);

    localparam logic [CNT_W-1:0] RST_LOAD = CNT_W'(RST_CYCLES);

    logic [1:0]        state_q, state_d;
    logic [NUM_CH-1:0] mask_q, mask_d;
    logic [NUM_CH-1:0] clock_en_q, clock_en_d;
    // Cycles left in the current counted run or core-reset window, including the current one
    logic [CNT_W-1:0]  left_q, left_d;
    logic              core_reset_q, core_reset_d;
    logic              done_q, done_d;
    logic              running;
    logic              cmd_acc;
    logic              halt_now;
    logic              cyc_clr;
    logic [NUM_CH-1:0] bp_match;

`ifdef SNURISC_RUNCTRL_BREAK_EN
    logic [NUM_CH-1:0] bp_hit_q, bp_hit_d;

    // A channel only breaks while it is actually being clocked
    always_comb begin
        bp_match = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            bp_match[k] = i_bp_valid && clock_en_q[k] && (i_pc[k*PC_W +: PC_W] == i_bp_addr);
        end
    end
`else
    assign bp_match = '0;
`endif

    always_comb begin
        running = is_run_state(state_q);
        case (state_q)
            ST_IDLE: o_cmd_ready = 1'b1;
            ST_CRST: o_cmd_ready = 1'b0;
            default: o_cmd_ready = (i_cmd_op == OP_HALT);
        endcase
        cmd_acc = i_cmd_valid && o_cmd_ready;
        // While running only HALT can be accepted; a breakpoint behaves the same way
        halt_now = running && (cmd_acc || (|bp_match));

        state_d = state_q;
        mask_d  = mask_q;
        left_d  = left_q;
        done_d  = 1'b0;
        cyc_clr = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cmd_acc) begin
                    case (i_cmd_op)
                        OP_HALT: done_d = 1'b1;
                        OP_RUN_FREE: begin
                            mask_d  = i_cmd_mask;
                            cyc_clr = 1'b1;
                            state_d = ST_RUN_FREE;
                        end
                        OP_RUN_COUNT: begin
                            if (i_cmd_count == '0) begin
                                done_d = 1'b1;
                            end else begin
                                mask_d  = i_cmd_mask;
                                left_d  = i_cmd_count;
                                cyc_clr = 1'b1;
                                state_d = ST_RUN_CNT;
                            end
                        end
                        default: begin
                            left_d  = RST_LOAD;
                            state_d = ST_CRST;
                        end
                    endcase
                end
            end
            ST_CRST: begin
                if (left_q == CNT_W'(1)) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    left_d = left_q - CNT_W'(1);
                end
            end
            ST_RUN_FREE: begin
                if (halt_now) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                // HALT on the final counted cycle still yields a single done pulse
                if (halt_now || (left_q == CNT_W'(1))) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    left_d = left_q - CNT_W'(1);
                end
            end
        endcase

        clock_en_d   = is_run_state(state_d) ? mask_d : '0;
        core_reset_d = (state_d == ST_CRST);
    end

`ifdef SNURISC_RUNCTRL_BREAK_EN
    always_comb begin
        bp_hit_d = bp_hit_q;
        if ((state_q == ST_IDLE) && cmd_acc &&
            ((i_cmd_op == OP_RUN_FREE) || (i_cmd_op == OP_RUN_COUNT))) begin
            bp_hit_d = '0;
        end else if (running) begin
            bp_hit_d = bp_hit_q | bp_match;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            bp_hit_q <= '0;
        end else begin
            bp_hit_q <= bp_hit_d;
        end
    end

    assign o_bp_hit = bp_hit_q;
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q      <= ST_IDLE;
            mask_q       <= '0;
            left_q       <= '0;
            clock_en_q   <= '0;
            core_reset_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            mask_q       <= mask_d;
            left_q       <= left_d;
            clock_en_q   <= clock_en_d;
            core_reset_q <= core_reset_d;
            done_q       <= done_d;
        end
    end

    // Counts every cycle spent in a run state, whatever the mask
    snurisc_sat_counter #(
        .CNT_W (CNT_W)
    ) u_cycles (
        .clk (i_clk),
        .rst (i_reset),
        .clr (cyc_clr),
        .inc (running),
        .cnt (o_cycles)
    );

    assign o_clock_en   = clock_en_q;
    assign o_core_reset = core_reset_q;
    assign o_done       = done_q;
    assign o_busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_snurisc_run_ctrl.sv
// Directed bench for snurisc_run_ctrl with a cycle-level reference model and literal spot checks.
module tb_snurisc_run_ctrl;

    localparam int NCH  = 2;
    localparam int CW   = 4;
    localparam int RSTC = 4;
    localparam int PCW  = 8;
    localparam int CMAX = (1 << CW) - 1;

    logic            clk = 1'b0;
    logic            i_reset;
    logic            i_cmd_valid;
    logic            o_cmd_ready;
    logic [1:0]      i_cmd_op;
    logic [CW-1:0]   i_cmd_count;
    logic [NCH-1:0]  i_cmd_mask;
    logic [NCH-1:0]  o_clock_en;
    logic            o_core_reset;
    logic            o_busy;
    logic            o_done;
    logic [CW-1:0]   o_cycles;
`ifdef SNURISC_RUNCTRL_BREAK_EN
    logic [NCH*PCW-1:0] i_pc;
    logic [PCW-1:0]     i_bp_addr;
    logic               i_bp_valid;
    logic [NCH-1:0]     o_bp_hit;
`endif

    always #5 clk = ~clk;

    snurisc_run_ctrl #(
        .NUM_CH     (NCH),
        .CNT_W      (CW),
        .RST_CYCLES (RSTC),
        .PC_W       (PCW)
    ) dut (
        .i_clk        (clk),
        .i_reset      (i_reset),
        .i_cmd_valid  (i_cmd_valid),
        .o_cmd_ready  (o_cmd_ready),
        .i_cmd_op     (i_cmd_op),
        .i_cmd_count  (i_cmd_count),
        .i_cmd_mask   (i_cmd_mask),
`ifdef SNURISC_RUNCTRL_BREAK_EN
        .i_pc         (i_pc),
        .i_bp_addr    (i_bp_addr),
        .i_bp_valid   (i_bp_valid),
        .o_bp_hit     (o_bp_hit),
`endif
        .o_clock_en   (o_clock_en),
        .o_core_reset (o_core_reset),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_cycles     (o_cycles)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Activity: 0 idle, 1 free run, 2 counted run, 3 core reset window
    int             m_act = 0;
    int             m_left = 0;     // enabled / reset cycles still to go
    int             m_cycles = 0;   // run cycles since last start, clamped
    logic [NCH-1:0] m_mask = '0;
    logic [NCH-1:0] m_hit = '0;
    bit             m_done = 0;
    bit             started = 0;
    bit             m_acc;
    logic [NCH-1:0] m_match;

    function automatic bit m_running();
        return (m_act == 1) || (m_act == 2);
    endfunction

    function automatic bit m_ready(input logic [1:0] op);
        if (m_act == 0) return 1'b1;
        if (m_act == 3) return 1'b0;
        return op == 2'd0;
    endfunction

    always @(posedge clk) begin
        if (i_reset) begin
            m_act = 0; m_left = 0; m_cycles = 0; m_mask = '0; m_hit = '0; m_done = 0;
            started = 1;
        end else begin
            m_acc   = i_cmd_valid && m_ready(i_cmd_op);
            m_match = '0;
`ifdef SNURISC_RUNCTRL_BREAK_EN
            if (m_running() && i_bp_valid)
                for (int k = 0; k < NCH; k++)
                    if (m_mask[k] && (i_pc[k*PCW +: PCW] == i_bp_addr)) m_match[k] = 1'b1;
`endif
            m_done = 0;
            if (m_running()) m_cycles = (m_cycles >= CMAX) ? CMAX : m_cycles + 1;
            if (m_running() && (m_acc || (m_match != '0))) begin
                m_act = 0; m_done = 1; m_hit = m_hit | m_match;
            end else if (m_act == 2 || m_act == 3) begin
                m_left = m_left - 1;
                if (m_left == 0) begin m_act = 0; m_done = 1; end
            end else if (m_act == 0 && m_acc) begin
                case (i_cmd_op)
                    2'd0: m_done = 1;
                    2'd1: begin m_act = 1; m_mask = i_cmd_mask; m_cycles = 0; m_hit = '0; end
                    2'd2: begin
                        m_hit = '0;
                        if (i_cmd_count == 0) m_done = 1;
                        else begin
                            m_act = 2; m_left = int'(i_cmd_count); m_mask = i_cmd_mask; m_cycles = 0;
                        end
                    end
                    default: begin m_act = 3; m_left = RSTC; end
                endcase
            end
        end
    end

    // ---------------- per-cycle compare + event counters ----------------
    int en_cnt = 0, done_cnt = 0, crst_cnt = 0;

    always @(negedge clk) begin
        if (started) begin
            check("clock_en",   32'(o_clock_en),   m_running() ? 32'(m_mask) : 32'd0);
            check("core_reset", 32'(o_core_reset), 32'(m_act == 3));
            check("busy",       32'(o_busy),       32'(m_act != 0));
            check("done",       32'(o_done),       32'(m_done));
            check("cycles",     32'(o_cycles),     32'(m_cycles));
            check("cmd_ready",  32'(o_cmd_ready),  32'(m_ready(i_cmd_op)));
`ifdef SNURISC_RUNCTRL_BREAK_EN
            check("bp_hit",     32'(o_bp_hit),     32'(m_hit));
`endif
            if (o_clock_en != '0) en_cnt++;
            if (o_done) done_cnt++;
            if (o_core_reset) crst_cnt++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic clr_counts();
        en_cnt = 0; done_cnt = 0; crst_cnt = 0;
    endtask

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Present a command and hold it until the handshake edge; returns in the cycle after it
    task automatic send(input logic [1:0] op, input logic [CW-1:0] cnt, input logic [NCH-1:0] mask);
        bit r;
        int n;
        i_cmd_op = op; i_cmd_count = cnt; i_cmd_mask = mask; i_cmd_valid = 1'b1;
        #1;
        n = 0;
        do begin
            r = o_cmd_ready;
            @(posedge clk); #1;
            n++;
        end while (!r && n < 64);
        if (!r) begin errors++; $display("FAIL send_timeout: ready never seen, op %0d", op); end
        i_cmd_valid = 1'b0;
    endtask

    // Wait until idle, then past the negedge of that cycle so its done pulse is counted
    task automatic wait_idle();
        int n;
        n = 0;
        while (o_busy && n < 100) begin @(posedge clk); #1; n++; end
        if (o_busy) begin errors++; $display("FAIL idle_timeout: busy %0d expected 0", o_busy); end
        @(negedge clk); #1;
    endtask

    initial begin
        i_reset = 1'b1; i_cmd_valid = 1'b0; i_cmd_op = 2'd0; i_cmd_count = '0; i_cmd_mask = '0;
`ifdef SNURISC_RUNCTRL_BREAK_EN
        i_pc = {8'h20, 8'h10}; i_bp_addr = 8'h40; i_bp_valid = 1'b0;
`endif
        tick(2);
        i_reset = 1'b0;
        check("rst_ready", 32'(o_cmd_ready), 32'd1);
        check("rst_cycles", 32'(o_cycles), 32'd0);

        // Counted run of 5 on channel 0
        clr_counts();
        send(2'd2, 4'd5, 2'b01);
        wait_idle();
        check("cnt5_en_cycles", en_cnt, 5);
        check("cnt5_done", done_cnt, 1);
        check("cnt5_cycles", 32'(o_cycles), 32'd5);

        // N = 0 then single step
        clr_counts();
        send(2'd2, 4'd0, 2'b11);
        wait_idle();
        check("cnt0_en_cycles", en_cnt, 0);
        check("cnt0_done", done_cnt, 1);
        check("cnt0_cycles_hold", 32'(o_cycles), 32'd5);
        clr_counts();
        send(2'd2, 4'd1, 2'b10);
        wait_idle();
        check("step_en_cycles", en_cnt, 1);
        check("step_cycles", 32'(o_cycles), 32'd1);

        // Zero mask counted run: timing and counter still advance
        clr_counts();
        send(2'd2, 4'd3, 2'b00);
        wait_idle();
        check("zmask_en_cycles", en_cnt, 0);
        check("zmask_cycles", 32'(o_cycles), 32'd3);
        check("zmask_done", done_cnt, 1);

        // Core reset, with a RUN_FREE queued behind it
        clr_counts();
        send(2'd3, 4'd0, 2'b00);
        check("crst_ready_low", 32'(o_cmd_ready), 32'd0);
        send(2'd1, 4'd0, 2'b10);
        check("crst_len", crst_cnt, RSTC);
        check("crst_done", done_cnt, 1);
        check("queued_run_en", 32'(o_clock_en), 32'd2);
        send(2'd0, 4'd0, 2'b00);
        wait_idle();

        // Free run halted at cycle 10 while a RUN_COUNT is stalled
        clr_counts();
        send(2'd1, 4'd0, 2'b11);
        i_cmd_op = 2'd2; i_cmd_count = 4'd3; i_cmd_valid = 1'b1;
        tick(4);
        check("stall_ready", 32'(o_cmd_ready), 32'd0);
        tick(5);
        i_cmd_op = 2'd0;
        tick(1);
        i_cmd_valid = 1'b0;
        check("halt_en_off", 32'(o_clock_en), 32'd0);
        wait_idle();
        check("halt_cycles", 32'(o_cycles), 32'd10);
        check("halt_en_cycles", en_cnt, 10);
        check("halt_done", done_cnt, 1);

        // Saturation: 20-cycle free run on a 4-bit counter
        send(2'd1, 4'd0, 2'b01);
        tick(19);
        send(2'd0, 4'd0, 2'b00);
        wait_idle();
        check("sat_cycles", 32'(o_cycles), 32'd15);

        // Back-to-back: new command accepted in the done cycle
        send(2'd2, 4'd2, 2'b01);
        tick(2);
        check("b2b_done", 32'(o_done), 32'd1);
        send(2'd2, 4'd1, 2'b10);
        check("b2b_en", 32'(o_clock_en), 32'd2);
        wait_idle();

        // HALT landing on the final counted cycle
        clr_counts();
        send(2'd2, 4'd3, 2'b01);
        tick(2);
        send(2'd0, 4'd0, 2'b00);
        wait_idle();
        check("halt_last_done", done_cnt, 1);
        check("halt_last_cycles", 32'(o_cycles), 32'd3);

`ifdef SNURISC_RUNCTRL_BREAK_EN
        // Breakpoint on channel 1 in run cycle 7
        i_bp_valid = 1'b1;
        send(2'd1, 4'd0, 2'b11);
        tick(6);
        i_pc = {8'h40, 8'h10};
        tick(1);
        i_pc = {8'h20, 8'h10};
        check("bp_en_off", 32'(o_clock_en), 32'd0);
        check("bp_hit_val", 32'(o_bp_hit), 32'd2);
        check("bp_cycles", 32'(o_cycles), 32'd7);
        i_bp_valid = 1'b0;
        send(2'd2, 4'd1, 2'b01);
        check("bp_hit_clr", 32'(o_bp_hit), 32'd0);
        wait_idle();
`endif

        // Reset held 3 cycles mid free run
        clr_counts();
        send(2'd1, 4'd0, 2'b11);
        tick(3);
        i_reset = 1'b1;
        tick(3);
        i_reset = 1'b0;
        check("mid_rst_en", 32'(o_clock_en), 32'd0);
        check("mid_rst_ready", 32'(o_cmd_ready), 32'd1);
        check("mid_rst_cycles", 32'(o_cycles), 32'd0);
        tick(2);
        check("mid_rst_no_done", done_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute time bound so the bench cannot hang
    initial begin
        #200000;
        $display("FAIL global_timeout: time %0t limit 200000", $time);
        $fatal(1);
    end

endmodule
